hop_phase_nco: RTL and testbench

- Downstream consumer of the frequency-hop scheduler's CtrlPort write stream; lives in the radio/DDS side of the chain.
- Accepts phase-increment writes on CtrlPort, queues them in a small FIFO, and applies them glitch-free at sample boundaries to a phase accumulator.
- Emits an AXI-Stream of phase words for the downstream sin/cos stage.
- Also exposes control and status registers on the same CtrlPort.

---
 rtl/hop_phase_nco_pkg.sv | 21 ++
 rtl/hop_inc_fifo.sv | 51 +++++
 rtl/hop_phase_nco.sv | 154 +++++++++++++++
 tb/tb_hop_phase_nco.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hop_phase_nco_pkg.sv
// Shared register map, bit positions and stream FSM encoding
// for the hop-scheduled phase NCO.
package hop_phase_nco_pkg;

   localparam int OFF_INC    = 0;
   localparam int OFF_CTRL   = 4;
   localparam int OFF_STATUS = 8;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;

   localparam int STAT_OVF    = 8;
   localparam int STAT_HOP_LO = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOPPING
   } state_t;

endpackage

// File: rtl/hop_inc_fifo.sv
// Small synchronous FIFO holding pending phase increments.
// A push into a full FIFO is taken only when a pop frees a slot.
module hop_inc_fifo #(
   parameter int AW = 2,
   parameter int W  = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_pop;
   logic         do_push;

   assign level   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = level[AW];
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (flush)
            rd_ptr <= wr_ptr;
         else if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/hop_phase_nco.sv
// Phase accumulator NCO: queued increments from CtrlPort are applied
// at sample boundaries; phase words leave on an AXI-Stream.
module hop_phase_nco
   import hop_phase_nco_pkg::*;
#(
   parameter int BASE_ADDR = 132,
   parameter int FIFO_AW   = 2,
   parameter int PHASE_W   = 32,
   parameter int OUT_W     = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               s_ctrlport_req_wr,
   input  logic               s_ctrlport_req_rd,
   input  logic [19:0]        s_ctrlport_req_addr,
   input  logic [31:0]        s_ctrlport_req_data,
   output logic               s_ctrlport_resp_ack,
   output logic [31:0]        s_ctrlport_resp_data,
   output logic [OUT_W-1:0]   m_phase_tdata,
   output logic               m_phase_tuser,
   output logic               m_phase_tvalid,
   input  logic               m_phase_tready,
   output logic [15:0]        hop_count
);

   localparam logic [19:0] ADDR_INC  = 20'(BASE_ADDR + OFF_INC);
   localparam logic [19:0] ADDR_CTRL = 20'(BASE_ADDR + OFF_CTRL);
   localparam logic [19:0] ADDR_STAT = 20'(BASE_ADDR + OFF_STATUS);

   state_t             state;
   logic               en;
   logic               ovf;
   logic [PHASE_W-1:0] acc;
   logic [PHASE_W-1:0] inc;

   logic               wr;
   logic               rd;
   logic               wr_inc;
   logic               wr_ctrl;
   logic               wr_stat;
   logic               flush;
   logic               adv;
   logic               pop;
   logic [PHASE_W-1:0] f_dout;
   logic [FIFO_AW:0]   f_level;
   logic               f_full;
   logic               f_empty;
   logic [31:0]        status;

   // a simultaneous read is ignored so the cycle acts as a plain write
   assign wr      = s_ctrlport_req_wr;
   assign rd      = s_ctrlport_req_rd && !s_ctrlport_req_wr;
   assign wr_inc  = wr && (s_ctrlport_req_addr == ADDR_INC);
   assign wr_ctrl = wr && (s_ctrlport_req_addr == ADDR_CTRL);
   assign wr_stat = wr && (s_ctrlport_req_addr == ADDR_STAT);
   assign flush   = wr_ctrl && s_ctrlport_req_data[CTRL_FLUSH];

   assign adv = (state == RUN) && en
             && (!m_phase_tvalid || m_phase_tready);
   assign pop = adv && !f_empty && !flush;

   always_comb begin
      status = '0;
      status[FIFO_AW:0] = f_level;
      status[STAT_OVF] = ovf;
      status[STAT_HOP_LO +: 16] = hop_count;
   end

   hop_inc_fifo #(
      .AW (FIFO_AW),
      .W  (PHASE_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (wr_inc),
      .pop     (pop),
      .flush   (flush),
      .din     (s_ctrlport_req_data[PHASE_W-1:0]),
      .dout    (f_dout),
      .level   (f_level),
      .full    (f_full),
      .empty   (f_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_ctrlport_resp_ack  <= 1'b0;
         s_ctrlport_resp_data <= '0;
         en                   <= 1'b0;
         ovf                  <= 1'b0;
      end else begin
         s_ctrlport_resp_ack  <= wr || s_ctrlport_req_rd;
         s_ctrlport_resp_data <= '0;
         if (rd && s_ctrlport_req_addr == ADDR_STAT)
            s_ctrlport_resp_data <= status;
         else if (rd && s_ctrlport_req_addr == ADDR_CTRL)
            s_ctrlport_resp_data <= {31'b0, en};
         if (wr_ctrl) en <= s_ctrlport_req_data[CTRL_EN];
         if (wr_inc && f_full && !pop)
            ovf <= 1'b1;
         else if (wr_stat && s_ctrlport_req_data[STAT_OVF])
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         acc            <= '0;
         inc            <= '0;
         m_phase_tvalid <= 1'b0;
         m_phase_tdata  <= '0;
         m_phase_tuser  <= 1'b0;
         hop_count      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) state <= RUN;
            end
            RUN: begin
               if (!en) begin
                  if (m_phase_tvalid && !m_phase_tready) begin
                     state <= STOPPING;
                  end else begin
                     state          <= IDLE;
                     m_phase_tvalid <= 1'b0;
                  end
               end else if (adv) begin
                  m_phase_tvalid <= 1'b1;
                  m_phase_tdata  <= acc[PHASE_W-1 -: OUT_W];
                  // the new step shows up from the sample after the marker
                  if (pop) begin
                     inc           <= f_dout;
                     acc           <= acc + f_dout;
                     m_phase_tuser <= 1'b1;
                     hop_count     <= hop_count + 16'd1;
                  end else begin
                     acc           <= acc + inc;
                     m_phase_tuser <= 1'b0;
                  end
               end
            end
            STOPPING: begin
               if (m_phase_tready) begin
                  m_phase_tvalid <= 1'b0;
                  state          <= en ? RUN : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hop_phase_nco.sv
// Directed bench for hop_phase_nco with a beat-level reference model.
module tb_hop_phase_nco;

   localparam logic [19:0] A_INC  = 20'h00084;
   localparam logic [19:0] A_CTRL = 20'h00088;
   localparam logic [19:0] A_STAT = 20'h0008C;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        s_ctrlport_req_wr = 1'b0;
   logic        s_ctrlport_req_rd = 1'b0;
   logic [19:0] s_ctrlport_req_addr = '0;
   logic [31:0] s_ctrlport_req_data = '0;
   logic        s_ctrlport_resp_ack;
   logic [31:0] s_ctrlport_resp_data;
   logic [15:0] m_phase_tdata;
   logic        m_phase_tuser;
   logic        m_phase_tvalid;
   logic        m_phase_tready = 1'b0;
   logic [15:0] hop_count;

   int checks = 0;
   int errors = 0;

   // reference model: one step per accepted beat
   logic [31:0] m_acc = '0;
   logic [31:0] m_inc = '0;
   logic [31:0] mq[$];
   logic [15:0] m_hops = '0;
   logic        m_ovf = 1'b0;
   bit          model_on = 1'b1;
   logic [16:0] beats[$];
   logic [15:0] e_data;
   logic        e_user;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;
   logic        prev_user = 1'b0;

   hop_phase_nco dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .s_ctrlport_req_wr    (s_ctrlport_req_wr),
      .s_ctrlport_req_rd    (s_ctrlport_req_rd),
      .s_ctrlport_req_addr  (s_ctrlport_req_addr),
      .s_ctrlport_req_data  (s_ctrlport_req_data),
      .s_ctrlport_resp_ack  (s_ctrlport_resp_ack),
      .s_ctrlport_resp_data (s_ctrlport_resp_data),
      .m_phase_tdata        (m_phase_tdata),
      .m_phase_tuser        (m_phase_tuser),
      .m_phase_tvalid       (m_phase_tvalid),
      .m_phase_tready       (m_phase_tready),
      .hop_count            (hop_count)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         m_acc = '0;
         m_inc = '0;
         mq.delete();
         m_hops = '0;
         m_ovf = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 32'(m_phase_tvalid), 32'd1);
            check("hold_data", 32'(m_phase_tdata), 32'(prev_data));
            check("hold_user", 32'(m_phase_tuser), 32'(prev_user));
         end
         if (model_on && m_phase_tvalid && m_phase_tready) begin
            e_data = m_acc[31:16];
            e_user = (mq.size() > 0);
            if (e_user) begin
               m_inc = mq.pop_front();
               m_hops++;
            end
            m_acc = m_acc + m_inc;
            check("beat_data", 32'(m_phase_tdata), 32'(e_data));
            check("beat_user", 32'(m_phase_tuser), 32'(e_user));
            beats.push_back({m_phase_tuser, m_phase_tdata});
         end
         if (model_on && s_ctrlport_req_wr) begin
            if (s_ctrlport_req_addr == A_INC) begin
               if (mq.size() < 4) mq.push_back(s_ctrlport_req_data);
               else m_ovf = 1'b1;
            end else if (s_ctrlport_req_addr == A_CTRL) begin
               if (s_ctrlport_req_data[1]) mq.delete();
            end else if (s_ctrlport_req_addr == A_STAT) begin
               if (s_ctrlport_req_data[8]) m_ovf = 1'b0;
            end
         end
         prev_stall = m_phase_tvalid && !m_phase_tready;
         prev_data = m_phase_tdata;
         prev_user = m_phase_tuser;
      end
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(logic [19:0] a, logic [31:0] d);
      tick();
      s_ctrlport_req_wr = 1'b1;
      s_ctrlport_req_addr = a;
      s_ctrlport_req_data = d;
      tick();
      s_ctrlport_req_wr = 1'b0;
      check("wr_ack", 32'(s_ctrlport_resp_ack), 32'd1);
   endtask

   task automatic rd(logic [19:0] a, output logic [31:0] d);
      tick();
      s_ctrlport_req_rd = 1'b1;
      s_ctrlport_req_addr = a;
      tick();
      s_ctrlport_req_rd = 1'b0;
      check("rd_ack", 32'(s_ctrlport_resp_ack), 32'd1);
      d = s_ctrlport_resp_data;
   endtask

   task automatic wait_beats(int n);
      int target;
      target = beats.size() + n;
      for (int i = 0; i < 400 && beats.size() < target; i++) tick();
      check("beat_timeout", 32'(beats.size() >= target), 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && m_phase_tvalid; i++) tick();
      check("idle_timeout", 32'(m_phase_tvalid), 32'd0);
   endtask

   function automatic int count_user(int from);
      int n = 0;
      for (int i = from; i < beats.size(); i++) n += int'(beats[i][16]);
      return n;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int b;

      // reset state
      tick(3);
      check("rst_tvalid", 32'(m_phase_tvalid), 32'd0);
      check("rst_tdata", 32'(m_phase_tdata), 32'd0);
      check("rst_hops", 32'(hop_count), 32'd0);
      check("rst_ack", 32'(s_ctrlport_resp_ack), 32'd0);
      reset_n = 1'b1;
      rd(A_STAT, d);
      check("rst_status", d, 32'h0);
      rd(A_CTRL, d);
      check("rst_ctrl", d, 32'h0);

      // basic hop followed by back-pressure
      wr(A_INC, 32'h0100_0000);
      m_phase_tready = 1'b1;
      wr(A_CTRL, 32'h1);
      wait_beats(4);
      check("hop_b0", 32'(beats[0]), 32'h0001_0000);
      check("hop_b1", 32'(beats[1]), 32'h0000_0100);
      check("hop_b2", 32'(beats[2]), 32'h0000_0200);
      check("hop_b3", 32'(beats[3]), 32'h0000_0300);
      check("hop_cnt1", 32'(hop_count), 32'd1);
      m_phase_tready = 1'b0;
      tick(5);
      m_phase_tready = 1'b1;
      wait_beats(6);
      wr(A_CTRL, 32'h0);
      wait_idle();
      check("hop_model", 32'(hop_count), 32'(m_hops));

      // overflow and W1C, with a combined wr+rd treated as write
      for (int i = 1; i <= 5; i++) wr(A_INC, 32'h0010_0000 * i);
      rd(A_STAT, d);
      check("ovf_status", d, 32'h0001_0104);
      check("ovf_model", 32'(m_ovf), 32'd1);
      tick();
      s_ctrlport_req_wr = 1'b1;
      s_ctrlport_req_rd = 1'b1;
      s_ctrlport_req_addr = A_STAT;
      s_ctrlport_req_data = 32'h100;
      tick();
      s_ctrlport_req_wr = 1'b0;
      s_ctrlport_req_rd = 1'b0;
      check("wrrd_ack", 32'(s_ctrlport_resp_ack), 32'd1);
      check("wrrd_data", s_ctrlport_resp_data, 32'h0);
      tick();
      check("wrrd_single", 32'(s_ctrlport_resp_ack), 32'd0);
      rd(A_STAT, d);
      check("w1c_status", d, 32'h0001_0004);

      // drain the four queued hops back to back
      b = beats.size();
      wr(A_CTRL, 32'h1);
      wait_beats(8);
      check("drain_users", 32'(count_user(b)), 32'd4);
      wr(A_CTRL, 32'h0);
      wait_idle();
      check("drain_hops", 32'(hop_count), 32'd5);

      // flush with three queued
      for (int i = 0; i < 3; i++) wr(A_INC, 32'h0700_0000);
      rd(A_STAT, d);
      check("pre_flush", d, 32'h0005_0003);
      wr(A_CTRL, 32'h2);
      rd(A_STAT, d);
      check("post_flush", d, 32'h0005_0000);
      rd(A_CTRL, d);
      check("flush_clear", d, 32'h0);
      b = beats.size();
      wr(A_CTRL, 32'h1);
      wait_beats(6);
      check("flush_nouser", 32'(count_user(b)), 32'd0);

      // stop while stalled
      m_phase_tready = 1'b0;
      tick(3);
      wr(A_CTRL, 32'h0);
      tick(3);
      check("stop_held", 32'(m_phase_tvalid), 32'd1);
      m_phase_tready = 1'b1;
      tick();
      check("stop_done", 32'(m_phase_tvalid), 32'd0);
      tick(3);
      check("stop_idle", 32'(m_phase_tvalid), 32'd0);
      check("stop_hops", 32'(hop_count), 32'd5);

      // reset mid-run drops outputs at once
      wr(A_CTRL, 32'h1);
      wait_beats(3);
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(m_phase_tvalid), 32'd0);
      check("mid_rst_hops", 32'(hop_count), 32'd0);
      tick(2);
      reset_n = 1'b1;
      tick(2);
      check("post_rst_valid", 32'(m_phase_tvalid), 32'd0);

      // half-turn increment and hop counter wrap
      wr(A_INC, 32'h8000_0000);
      b = beats.size();
      wr(A_CTRL, 32'h1);
      wait_beats(3);
      check("wrap_b0", 32'(beats[b]), 32'h0001_0000);
      check("wrap_b1", 32'(beats[b+1]), 32'h0000_8000);
      check("wrap_b2", 32'(beats[b+2]), 32'h0000_0000);
      model_on = 1'b0;
      tick();
      s_ctrlport_req_wr = 1'b1;
      s_ctrlport_req_addr = A_INC;
      s_ctrlport_req_data = 32'h0;
      tick(65534);
      s_ctrlport_req_wr = 1'b0;
      tick(8);
      check("hops_ffff", 32'(hop_count), 32'h0000_ffff);
      wr(A_INC, 32'h0);
      tick(8);
      check("hops_wrap", 32'(hop_count), 32'h0);
      rd(A_STAT, d);
      check("wrap_status", d, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
